// File: rtl/matrix_scan_sequencer_pkg.sv
// Shared state encoding, default geometry and width helpers for the LED matrix scan sequencer.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 16;

  // Width of a counter/index covering 0..n-1, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_scan_sequencer_if.sv
// Host bitmap write port: one matrix row per valid/ready transfer.
interface matrix_scan_sequencer_if
  import matrix_pkg::*;
#(
  parameter int FRAME_W = 3,
  parameter int ROW_W   = 4,
  parameter int COLS    = DEF_COLS
);
  logic               wr_valid;
  logic               wr_ready;
  logic [FRAME_W-1:0] wr_frame;
  logic [ROW_W-1:0]   wr_row;
  logic [COLS-1:0]    wr_data;

  modport master (output wr_valid, wr_frame, wr_row, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_frame, wr_row, wr_data, output wr_ready);
endinterface

// File: rtl/matrix_scan_sequencer_scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, i.e. load_val+1 cycles after a load.
module scan_timer #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign tc = (cnt_reg == '0);
endmodule

// File: rtl/matrix_scan_sequencer.sv
// Row-multiplexed scan of an animation ring of bitmaps, with a tear-free host write port.
module matrix_scan_sequencer
  import matrix_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int NFRAMES      = 8,
  parameter int DWELL        = 1024,
  parameter int BLANK        = 16,
  parameter int FRAME_REPEAT = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  matrix_scan_sequencer_if.slave       wr,
  output logic [0:ROWS-1]              row,
  output logic [COLS-1:0]              col,
  output logic [clog2w(NFRAMES)-1:0]   frame_idx,
  output logic                         frame_tick
);
  localparam int FRAME_W = clog2w(NFRAMES);
  localparam int ROW_W   = clog2w(ROWS);
  localparam int SCAN_W  = clog2w(FRAME_REPEAT);
  localparam int TMR_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int TMR_W   = clog2w(TMR_MAX);
  localparam logic [TMR_W-1:0] DWELL_LD = TMR_W'(DWELL - 1);
  localparam logic [TMR_W-1:0] BLANK_LD = TMR_W'(BLANK - 1);

  scan_state_t        state_reg, state_next;
  logic [ROW_W-1:0]   row_ptr_reg;
  logic [SCAN_W-1:0]  scan_cnt_reg;
  logic [FRAME_W-1:0] frame_idx_reg;
  logic               frame_tick_reg;
  logic               live_reg;
  logic [0:ROWS-1]    row_reg;
  logic [0:ROWS-1]    row_onehot;
  logic [COLS-1:0]    col_reg;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_tc;
  logic               row_adv;
  logic               wr_fire;
  logic [COLS-1:0]    mem [NFRAMES][ROWS];

  scan_timer #(.W(TMR_W)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign row_onehot[gi] = (row_ptr_reg == ROW_W'(gi));
  end

  // live_reg holds the port closed until the first clock after reset release.
  assign wr.wr_ready = live_reg &
                       ((state_reg == matrix_pkg::IDLE) | (wr.wr_frame != frame_idx_reg));
  assign wr_fire     = wr.wr_valid & wr.wr_ready;

  always_ff @(posedge clock) begin
    if (wr_fire && (32'(wr.wr_row) < ROWS)) begin
      mem[wr.wr_frame][wr.wr_row] <= wr.wr_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    tmr_load   = 1'b0;
    tmr_val    = BLANK_LD;
    row_adv    = 1'b0;
    case (state_reg)
      matrix_pkg::IDLE: begin
        if (enable) begin
          state_next = matrix_pkg::BLANK;
          tmr_load   = 1'b1;
        end
      end
      matrix_pkg::BLANK: begin
        if (tmr_tc) begin
          if (enable) begin
            state_next = matrix_pkg::SHOW;
            tmr_load   = 1'b1;
            tmr_val    = DWELL_LD;
          end else begin
            state_next = matrix_pkg::IDLE;
          end
        end
      end
      matrix_pkg::SHOW: begin
        if (tmr_tc) begin
          row_adv = 1'b1;
          if (enable) begin
            state_next = matrix_pkg::BLANK;
            tmr_load   = 1'b1;
          end else begin
            state_next = matrix_pkg::IDLE;
          end
        end
      end
      default: state_next = matrix_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= matrix_pkg::IDLE;
      row_ptr_reg    <= '0;
      scan_cnt_reg   <= '0;
      frame_idx_reg  <= '0;
      frame_tick_reg <= 1'b0;
      live_reg       <= 1'b0;
      row_reg        <= '0;
      col_reg        <= '1;
    end else begin
      state_reg      <= state_next;
      live_reg       <= 1'b1;
      frame_tick_reg <= 1'b0;
      // Drives lag the state by one clock; the shown frame is never written, so the read is stable.
      if (state_reg == matrix_pkg::SHOW) begin
        row_reg <= row_onehot;
        col_reg <= ~mem[frame_idx_reg][row_ptr_reg];
      end else begin
        row_reg <= '0;
        col_reg <= '1;
      end
      if (row_adv) begin
        if (row_ptr_reg == ROW_W'(ROWS - 1)) begin
          row_ptr_reg <= '0;
          if (scan_cnt_reg == SCAN_W'(FRAME_REPEAT - 1)) begin
            scan_cnt_reg   <= '0;
            frame_idx_reg  <= frame_idx_reg + 1'b1;
            frame_tick_reg <= 1'b1;
          end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
          end
        end else begin
          row_ptr_reg <= row_ptr_reg + 1'b1;
        end
      end
    end
  end

  assign row        = row_reg;
  assign col        = col_reg;
  assign frame_idx  = frame_idx_reg;
  assign frame_tick = frame_tick_reg;
endmodule
